gray_counter: RTL and testbench
===============================

# gray_counter

Registered up/down binary counter that presents its value in both binary and Gray code, with the two outputs always coherent. Its Gray output is the encode side of the `gray2bin` decoder: it produces single-bit-transition pointers for clock-domain crossings, such as async FIFO read/write pointers. The far side of the crossing recovers the binary value with `gray2bin`. The counter owns the state and the Gray encode, so no combinational encoder sits in front of a synchroniser.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: counter and output width in bits, minimum 2.
- `RESET_VALUE`, default 0: binary count loaded on reset, `DATA_WIDTH` bits.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `en`  in  1: count enable; one step per cycle while high.
- `up`  in  1: direction; 1 = increment, 0 = decrement. Sampled only when `en` is high.
- `load`  in  1: synchronous load strobe. Active only with `GRAY_CNT_LOAD_EN`.
- `load_value`  in  `DATA_WIDTH`: binary value to load. Active only with `GRAY_CNT_LOAD_EN`.
- `binary_out`  out  `DATA_WIDTH`: registered binary count.
- `gray_out`  out  `DATA_WIDTH`: registered Gray code of `binary_out`, equal to `binary_out ^ (binary_out >> 1)`.
- `wrap`  out  1: registered one-cycle pulse when the count wraps.

## Operation
- The state is the binary register `bin_q`. The next value `bin_d` is selected by priority:
  - `rst`: `RESET_VALUE`.
  - `load` (macro enabled only): `load_value`.
  - `en && up`: `bin_q + 1`, modulo 2^`DATA_WIDTH`.
  - `en && !up`: `bin_q - 1`, modulo 2^`DATA_WIDTH`.
  - Otherwise: hold.
- `gray_out` is registered from `bin2gray(bin_d)`, not from `bin_q`. Both outputs therefore update on the same edge, and `gray_out` is never combinationally derived downstream.
- Every count step changes exactly one bit of `gray_out`, including the wrap steps. Load and reset steps may change any number of bits.
- `wrap` is set for one cycle in either of these cases:
  - count step up from all-ones to zero;
  - count step down from zero to all-ones.
- `wrap` is 0 in all other cycles, including load cycles and reset.
- Hold leaves all outputs unchanged and `wrap` = 0.
- There is no state machine. Behaviour is a single register stage plus next-state logic.

## Timing
- Reset values:
  - `binary_out` = `RESET_VALUE`
  - `gray_out` = `bin2gray(RESET_VALUE)`
  - `wrap` = 0
- These values are visible the cycle after `rst` is sampled high.
- Latency: an `en`, `load` or `rst` sampled at edge N is reflected on all outputs after edge N; one-cycle latency.
- `wrap` asserts in the same cycle that the outputs show the wrapped value.
- Simultaneous events:
  - `rst` overrides `load` and `en`.
  - `load` overrides `en`. The load value appears with no step applied, and `wrap` = 0.
- Reset mid-count, with `en` held high: the next cycle shows the reset values, and counting resumes from `RESET_VALUE` on the following edge.
- `up` may change every cycle. Each step uses the `up` value sampled on that edge.

## Configuration
- Macro `GRAY_CNT_LOAD_EN`.
- Defined: `load` and `load_value` are functional, with the priority given above.
- Undefined:
  - `load` and `load_value` remain in the port list but are ignored.
  - No load mux is generated.
  - The counter changes only through `rst` and `en`.

## Structure
- A shared package `gray_pkg` holds:
  - the `bin2gray` function, width-generic;
  - direction constants `CNT_UP` = 1'b1 and `CNT_DOWN` = 1'b0.
- `gray2bin` consumers use the same package.
- Sub-module `bin2gray`: purely combinational, parameter `DATA_WIDTH`, ports `binary_in` and `gray_out`. It is instantiated once on `bin_d` and is reusable elsewhere.
- The top level `gray_counter` contains the next-state mux, the wrap detect and the output registers.

## Test plan
All scenarios use `DATA_WIDTH` = 8 and `RESET_VALUE` = 0.
- Reset, then idle: `binary_out` = 0x00, `gray_out` = 0x00, `wrap` = 0, held indefinitely while `en` = 0.
- `en` = 1, `up` = 1 for 256 cycles from 0:
  - `gray_out` differs from the previous cycle in exactly one bit every cycle;
  - at 0xFF→0x00, `gray_out` goes 0x80→0x00 with `wrap` = 1 for exactly one cycle;
  - `gray2bin(gray_out)` equals `binary_out` every cycle.
- `en` = 1, `up` = 0 from 0x00: next cycle `binary_out` = 0xFF, `gray_out` = 0x80, `wrap` = 1. The following cycle shows 0xFE / 0x81, `wrap` = 0.
- With `GRAY_CNT_LOAD_EN`, `load` = 1, `load_value` = 0x55 and `en` = 1 in the same cycle: next cycle `binary_out` = 0x55, `gray_out` = 0x7F, `wrap` = 0. Without the macro, the same stimulus gives 0x01 / 0x01.
- `rst` = 1 together with `load` = 1 and `en` = 1 while the count is 0x3C: next cycle shows 0x00 / 0x00, `wrap` = 0. Counting resumes at 0x01 after `rst` is deasserted.
- Alternate `up` 1/0 every cycle starting from 0x10, with `en` = 1: `binary_out` toggles 0x11 / 0x10, `gray_out` toggles 0x19 / 0x18, `wrap` stays 0.

Source files
------------

// File: rtl/gray_pkg.sv
// gray_pkg: shared Gray-code helpers and counter direction constants
package gray_pkg;
  localparam logic CNT_UP = 1'b1;
  localparam logic CNT_DOWN = 1'b0;
  function automatic logic [63:0] bin2gray(input logic [63:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [63:0] gray2bin(input logic [63:0] g);
    logic [63:0] b;
    b[63] = g[63];
    for (int i = 62; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/bin2gray.sv
// bin2gray: combinational binary to Gray encoder
module bin2gray #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] binary_in,
  output logic [DATA_WIDTH-1:0] gray_out
);
  assign gray_out = binary_in ^ (binary_in >> 1);
endmodule

// File: rtl/gray_counter.sv
// gray_counter: up/down counter with coherent registered binary and Gray outputs; GRAY_CNT_LOAD_EN enables load
module gray_counter
  import gray_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_value,
  output logic [DATA_WIDTH-1:0] binary_out,
  output logic [DATA_WIDTH-1:0] gray_out,
  output logic                  wrap
);
  localparam logic [DATA_WIDTH-1:0] RESET_GRAY = DATA_WIDTH'(bin2gray(64'(RESET_VALUE)));
  logic [DATA_WIDTH-1:0] bin_q, bin_d, gray_d;
  logic wrap_d;
`ifndef GRAY_CNT_LOAD_EN
  logic unused_load;
  assign unused_load = ^{load, load_value};
`endif
  // next count and wrap detect: wrap only on a count step across the all-ones/zero boundary
  always_comb begin
`ifdef GRAY_CNT_LOAD_EN
    bin_d = load ? load_value : en ? (up == CNT_UP ? bin_q + 1'b1 : bin_q - 1'b1) : bin_q;
    wrap_d = !load && en && (up == CNT_UP ? &bin_q : ~|bin_q);
`else
    bin_d = en ? (up == CNT_UP ? bin_q + 1'b1 : bin_q - 1'b1) : bin_q;
    wrap_d = en && (up == CNT_UP ? &bin_q : ~|bin_q);
`endif
  end
  bin2gray #(.DATA_WIDTH(DATA_WIDTH)) u_enc (.binary_in(bin_d), .gray_out(gray_d));
  // single register stage so binary and Gray update on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q <= RESET_VALUE;
      gray_out <= RESET_GRAY;
      wrap <= 1'b0;
    end else begin
      bin_q <= bin_d;
      gray_out <= gray_d;
      wrap <= wrap_d;
    end
  end
  assign binary_out = bin_q;
endmodule

// File: tb/tb_gray_counter.sv
// tb_gray_counter: model-checked directed test of gray_counter (DATA_WIDTH 8, RESET_VALUE 0)
module tb_gray_counter;
`ifdef GRAY_CNT_LOAD_EN
  localparam bit LOAD_ON = 1'b1;
`else
  localparam bit LOAD_ON = 1'b0;
`endif
  logic clk = 0, rst = 1, en = 0, up = 1, load = 0, wrap;
  logic [7:0] load_value = 0, binary_out, gray_out;
  int total = 0, bad = 0;
  int exp_bin = 0;
  logic [7:0] exp_gray = 0, prev_gray = 0;
  logic exp_wrap = 0, counted = 0, valid = 0;

  gray_counter #(.DATA_WIDTH(8), .RESET_VALUE(8'h00)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_value(load_value),
    .binary_out(binary_out), .gray_out(gray_out), .wrap(wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] g2b(input logic [7:0] g);
    logic [7:0] b;
    b[7] = g[7];
    for (int i = 6; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    int n;
    prev_gray = exp_gray;
    counted = 0;
    if (rst) begin
      exp_bin = 0;
      exp_wrap = 0;
      valid = 1;
    end else if (LOAD_ON && load) begin
      exp_bin = int'(load_value);
      exp_wrap = 0;
    end else if (en) begin
      n = up ? exp_bin + 1 : exp_bin - 1;
      exp_wrap = (n < 0) || (n > 255);
      exp_bin = (n + 256) % 256;
      counted = 1;
    end else exp_wrap = 0;
    exp_gray = 8'(exp_bin ^ (exp_bin >> 1));
  end

  always @(negedge clk) if (valid) begin
    chk("model_bin", 32'(binary_out), 32'(exp_bin));
    chk("model_gray", 32'(gray_out), 32'(exp_gray));
    chk("model_wrap", 32'(wrap), 32'(exp_wrap));
    chk("decode", 32'(g2b(gray_out)), 32'(binary_out));
    if (counted) chk("one_bit", 32'($countones(gray_out ^ prev_gray)), 32'd1);
  end

  task automatic lit(input string name, input logic [7:0] b, input logic [7:0] g, input logic w);
    chk({name, "_bin"}, 32'(binary_out), 32'(b));
    chk({name, "_gray"}, 32'(gray_out), 32'(g));
    chk({name, "_wrap"}, 32'(wrap), 32'(w));
  endtask

  task automatic do_reset();
    rst = 1; en = 0; load = 0;
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (4) @(negedge clk);
    lit("idle", 8'h00, 8'h00, 1'b0);
    en = 1; up = 1;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (i == 254) lit("top", 8'hFF, 8'h80, 1'b0);
      if (i == 255) lit("wrap_up", 8'h00, 8'h00, 1'b1);
    end
    en = 0;
    @(negedge clk);
    lit("after_wrap", 8'h00, 8'h00, 1'b0);
    en = 1; up = 0;
    @(negedge clk);
    lit("wrap_down", 8'hFF, 8'h80, 1'b1);
    @(negedge clk);
    lit("down2", 8'hFE, 8'h81, 1'b0);
    do_reset();
    load = 1; load_value = 8'h55; en = 1; up = 1;
    @(negedge clk);
    if (LOAD_ON) lit("load", 8'h55, 8'h7F, 1'b0);
    else lit("noload", 8'h01, 8'h01, 1'b0);
    load = 0;
    do_reset();
    en = 1; up = 1;
    repeat (60) @(negedge clk);
    lit("at3c", 8'h3C, 8'h22, 1'b0);
    rst = 1; load = 1;
    @(negedge clk);
    lit("rst_prio", 8'h00, 8'h00, 1'b0);
    rst = 0; load = 0;
    @(negedge clk);
    lit("resume", 8'h01, 8'h01, 1'b0);
    do_reset();
    en = 1; up = 1;
    repeat (16) @(negedge clk);
    lit("at10", 8'h10, 8'h18, 1'b0);
    for (int i = 0; i < 3; i++) begin
      up = 1;
      @(negedge clk);
      lit("alt_up", 8'h11, 8'h19, 1'b0);
      up = 0;
      @(negedge clk);
      lit("alt_dn", 8'h10, 8'h18, 1'b0);
    end
    en = 0;
    repeat (3) @(negedge clk);
    lit("hold", 8'h10, 8'h18, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
